palette_video_out: RTL and testbench

PALETTE_VIDEO_OUT -- requirements
Module: palette_video_out

---
 rtl/palette_video_out.sv | 129 ++++++++++++
 tb/tb_palette_video_out.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_video_out.sv
// rtl/palette_video_out.sv - two-stage palette lookup with a shadow palette committed on vsync
module palette_video_out #(
  parameter int   NUM_PAL     = 4,
  parameter int   PAL_ENTRIES = 8,
  parameter int   NUM_COLORS  = 64,
  parameter int   CH_W        = 8,
  parameter int   ACTIVE_W    = 512,
  parameter int   ACTIVE_H    = 480,
  parameter int   COORD_W     = 10,
  parameter logic SYNC_IDLE   = 1'b1,
  parameter int   PI_W        = $clog2(NUM_PAL) + $clog2(PAL_ENTRIES),
  parameter int   CI_W        = $clog2(NUM_COLORS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PI_W-1:0]     pix_in,
  input  logic [COORD_W-1:0]  x_in,
  input  logic [COORD_W-1:0]  y_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                de_in,
  input  logic                pal_wr_en,
  input  logic [PI_W-1:0]     pal_wr_addr,
  input  logic [CI_W-1:0]     pal_wr_data,
  input  logic                col_wr_en,
  input  logic [CI_W-1:0]     col_wr_addr,
  input  logic [3*CH_W-1:0]   col_wr_data,
  input  logic [3*CH_W-1:0]   border,
  output logic                commit_pending,
  output logic [CH_W-1:0]     r_out,
  output logic [CH_W-1:0]     g_out,
  output logic [CH_W-1:0]     b_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                de_out
);

  localparam int PAL_DEPTH = NUM_PAL * PAL_ENTRIES;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(ACTIVE_W);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(ACTIVE_H);

  logic [CI_W-1:0]   live_pal   [PAL_DEPTH];
  logic [CI_W-1:0]   shadow_pal [PAL_DEPTH];
  logic [3*CH_W-1:0] colours    [NUM_COLORS];
  logic              pending;

  logic [CI_W-1:0]   s1_idx;
  logic              s1_win;
  logic [3*CH_W-1:0] s2_rgb;
  logic              hs_d1, hs_d2, vs_d1, vs_d2, de_d1, de_d2;

  logic              commit_edge;
  logic              do_commit;

  // vs_d1 is last cycle's vsync_in, so it doubles as the edge detector history
  assign commit_edge = (vs_d1 == SYNC_IDLE) && (vsync_in != SYNC_IDLE);
  assign do_commit   = commit_edge && pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        live_pal[i]   <= '0;
        shadow_pal[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      // live copy samples shadow before any same-cycle write lands
      if (do_commit) begin
        for (int i = 0; i < PAL_DEPTH; i++) begin
          live_pal[i] <= shadow_pal[i];
        end
      end
      if (pal_wr_en) begin
        shadow_pal[pal_wr_addr] <= pal_wr_data;
      end
      if (pal_wr_en) begin
        pending <= 1'b1;
      end else if (do_commit) begin
        pending <= 1'b0;
      end
    end
  end

  // master colour table is deliberately left unreset
  always_ff @(posedge clk) begin
    if (col_wr_en) begin
      colours[col_wr_addr] <= col_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_idx <= '0;
      s1_win <= 1'b0;
      s2_rgb <= '0;
      hs_d1  <= SYNC_IDLE;
      hs_d2  <= SYNC_IDLE;
      vs_d1  <= SYNC_IDLE;
      vs_d2  <= SYNC_IDLE;
      de_d1  <= 1'b0;
      de_d2  <= 1'b0;
    end else begin
      s1_idx <= live_pal[pix_in];
      s1_win <= (x_in < X_LIM) && (y_in < Y_LIM);
      if (!de_d1) begin
        s2_rgb <= '0;
      end else if (s1_win) begin
        s2_rgb <= colours[s1_idx];
      end else begin
        s2_rgb <= border;
      end
      hs_d1 <= hsync_in;
      hs_d2 <= hs_d1;
      vs_d1 <= vsync_in;
      vs_d2 <= vs_d1;
      de_d1 <= de_in;
      de_d2 <= de_d1;
    end
  end

  assign r_out          = s2_rgb[3*CH_W-1 -: CH_W];
  assign g_out          = s2_rgb[2*CH_W-1 -: CH_W];
  assign b_out          = s2_rgb[CH_W-1:0];
  assign hsync_out      = hs_d2;
  assign vsync_out      = vs_d2;
  assign de_out         = de_d2;
  assign commit_pending = pending;

endmodule

// File: tb/tb_palette_video_out.sv
// tb/tb_palette_video_out.sv - self-checking bench for palette_video_out
module tb_palette_video_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  pix_in;
  logic [9:0]  x_in, y_in;
  logic        hsync_in, vsync_in, de_in;
  logic        pal_wr_en;
  logic [4:0]  pal_wr_addr;
  logic [5:0]  pal_wr_data;
  logic        col_wr_en;
  logic [5:0]  col_wr_addr;
  logic [23:0] col_wr_data;
  logic [23:0] border;
  logic        commit_pending;
  logic [7:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out, de_out;
  logic [23:0] rgb;

  assign rgb = {r_out, g_out, b_out};

  palette_video_out dut (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .x_in(x_in), .y_in(y_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
    .col_wr_en(col_wr_en), .col_wr_addr(col_wr_addr), .col_wr_data(col_wr_data),
    .border(border), .commit_pending(commit_pending),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: output at edge t reflects inputs and live palette seen at t-1, colour table at t
  logic [5:0]  m_live [32];
  logic [5:0]  m_shadow [32];
  logic [23:0] m_col [64];
  bit          m_ok [64];
  bit          m_pend = 1'b0;
  logic        m_vsp = 1'b1;
  logic [5:0]  p_ci = '0;
  bit          p_win = 1'b0;
  logic        p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
  logic [23:0] e_rgb = '0;
  bit          e_known = 1'b1;
  logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1;
  bit          fire;

  initial begin
    for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) begin
          m_live[i] = '0;
          m_shadow[i] = '0;
        end
        m_pend = 1'b0; m_vsp = 1'b1;
        p_ci = '0; p_win = 1'b0; p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        e_rgb = '0; e_known = 1'b1; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        e_de = p_de; e_hs = p_hs; e_vs = p_vs;
        if (!p_de) begin
          e_rgb = '0; e_known = 1'b1;
        end else if (p_win) begin
          e_rgb = m_col[p_ci]; e_known = m_ok[p_ci];
        end else begin
          e_rgb = border; e_known = 1'b1;
        end
        p_ci  = m_live[pix_in];
        p_win = (x_in < 10'd512) && (y_in < 10'd480);
        p_de  = de_in; p_hs = hsync_in; p_vs = vsync_in;
        fire = m_pend && m_vsp && !vsync_in;
        if (fire) m_live = m_shadow;
        if (pal_wr_en) begin
          m_shadow[pal_wr_addr] = pal_wr_data;
          m_pend = 1'b1;
        end else if (fire) begin
          m_pend = 1'b0;
        end
        m_vsp = vsync_in;
        if (col_wr_en) begin
          m_col[col_wr_addr] = col_wr_data;
          m_ok[col_wr_addr] = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (e_known) chk("model_rgb", 32'(rgb), 32'(e_rgb));
      chk("model_de", 32'(de_out), 32'(e_de));
      chk("model_hsync", 32'(hsync_out), 32'(e_hs));
      chk("model_vsync", 32'(vsync_out), 32'(e_vs));
      chk("model_pending", 32'(commit_pending), 32'(m_pend));
    end
  end

  initial begin
    reset_n = 1'b0; pix_in = '0; x_in = '0; y_in = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
    col_wr_en = 1'b0; col_wr_addr = '0; col_wr_data = '0; border = '0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_flags", 32'({hsync_out, vsync_out, de_out, commit_pending}), 32'hC);
    reset_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      col_wr_en = 1'b1; col_wr_addr = 6'(i);
      col_wr_data = (i == 5) ? 24'h112233 : {8'(i), 8'(i + 1), 8'(i + 2)};
      @(negedge clk);
    end
    col_wr_en = 1'b0;

    pal_wr_en = 1'b1; pal_wr_addr = 5'd10; pal_wr_data = 6'd5;
    @(negedge clk);
    pal_wr_en = 1'b0;
    chk("pend_after_write", 32'(commit_pending), 32'h1);
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    chk("pend_after_commit", 32'(commit_pending), 32'h0);

    pix_in = 5'd10; x_in = 10'd10; y_in = 10'd10; de_in = 1'b1;
    @(negedge clk);
    chk("lat1_de", 32'(de_out), 32'h0);
    @(negedge clk);
    chk("lat2_rgb", 32'(rgb), 32'h112233);
    chk("lat2_de", 32'(de_out), 32'h1);

    border = 24'h0000FF; x_in = 10'd512;
    repeat (2) @(negedge clk);
    chk("x512_border", 32'(rgb), 32'h0000FF);
    x_in = 10'd511;
    repeat (2) @(negedge clk);
    chk("x511_inside", 32'(rgb), 32'h112233);
    x_in = 10'd10; y_in = 10'd480;
    repeat (2) @(negedge clk);
    chk("y480_border", 32'(rgb), 32'h0000FF);
    y_in = 10'd479;
    repeat (2) @(negedge clk);
    chk("y479_inside", 32'(rgb), 32'h112233);
    de_in = 1'b0; x_in = 10'd512;
    repeat (2) @(negedge clk);
    chk("de0_blank", 32'(rgb), 32'h0);
    de_in = 1'b1; x_in = 10'd10; y_in = 10'd10;
    repeat (2) @(negedge clk);

    pal_wr_en = 1'b1; pal_wr_data = 6'd7;
    @(negedge clk);
    pal_wr_en = 1'b0;
    chk("shadow_pend", 32'(commit_pending), 32'h1);
    chk("shadow_nochange", 32'(rgb), 32'h112233);
    @(negedge clk);
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    chk("commit_clears", 32'(commit_pending), 32'h0);
    @(negedge clk);
    chk("commit_edge_pixel_old", 32'(rgb), 32'h112233);
    @(negedge clk);
    chk("commit_new_colour", 32'(rgb), 32'h070809);

    pal_wr_en = 1'b1; pal_wr_data = 6'd20;
    @(negedge clk);
    pal_wr_en = 1'b0;
    @(negedge clk);
    vsync_in = 1'b0; pal_wr_en = 1'b1; pal_wr_data = 6'd9;
    @(negedge clk);
    pal_wr_en = 1'b0; vsync_in = 1'b1;
    chk("coincide_pend", 32'(commit_pending), 32'h1);
    repeat (2) @(negedge clk);
    chk("coincide_old_live", 32'(rgb), 32'h141516);
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    chk("second_commit_pend", 32'(commit_pending), 32'h0);
    repeat (2) @(negedge clk);
    chk("second_commit_rgb", 32'(rgb), 32'h090A0B);

    col_wr_en = 1'b1; col_wr_addr = 6'd9; col_wr_data = 24'hABCDEF;
    @(negedge clk);
    col_wr_en = 1'b0;
    chk("colwr_old", 32'(rgb), 32'h090A0B);
    @(negedge clk);
    chk("colwr_new", 32'(rgb), 32'hABCDEF);

    hsync_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_hs", 32'(hsync_out), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'h0);
    chk("async_rst_flags", 32'({hsync_out, vsync_out, de_out}), 32'h6);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; hsync_in = 1'b1;
    @(negedge clk);
    chk("post_rst1_de", 32'(de_out), 32'h0);
    @(negedge clk);
    chk("post_rst2_rgb", 32'(rgb), 32'h000102);
    chk("post_rst2_de", 32'(de_out), 32'h1);

    for (int n = 0; n < 400; n++) begin
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      de_in    = 1'($urandom_range(0, 1));
      pix_in   = 5'($urandom_range(0, 31));
      x_in     = 10'($urandom_range(0, 600));
      y_in     = 10'($urandom_range(0, 540));
      border   = 24'($urandom);
      pal_wr_en = ($urandom_range(0, 7) == 0);
      pal_wr_addr = 5'($urandom_range(0, 31));
      pal_wr_data = 6'($urandom_range(0, 63));
      col_wr_en = ($urandom_range(0, 15) == 0);
      col_wr_addr = 6'($urandom_range(0, 63));
      col_wr_data = 24'($urandom);
      @(negedge clk);
    end
    pal_wr_en = 1'b0; col_wr_en = 1'b0; de_in = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
